// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W     = 5;
  localparam int unsigned TNEW_W    = 4;
  localparam int unsigned TUSE_W    = 2;
  localparam int unsigned FWD_SEL_W = 2;

  localparam int unsigned MULT_CYCLES_DEF = 5;
  localparam int unsigned DIV_CYCLES_DEF  = 10;
  localparam int unsigned CNT_W_DEF       = 4;

  localparam logic [FWD_SEL_W-1:0] FWD_GRF = 2'd0;
  localparam logic [FWD_SEL_W-1:0] FWD_E   = 2'd1;
  localparam logic [FWD_SEL_W-1:0] FWD_M   = 2'd2;
  localparam logic [FWD_SEL_W-1:0] FWD_W   = 2'd3;

  // $0 is hard-wired, so a write to it never produces a dependency.
  function automatic logic reg_match(input logic             we,
                                     input logic [REG_W-1:0] dst,
                                     input logic [REG_W-1:0] src);
    return we && (dst == src) && (src != '0);
  endfunction

endpackage

// File: rtl/hazard_ctrl_md_busy_seq.sv
// Mult/div busy sequencer: one down-counter loaded on an accepted start.
module hazard_ctrl_md_busy_seq
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_is_div,
  output logic o_busy
);

  logic [CNT_W-1:0] r_cnt;

  // A start arriving while busy is dropped; the D-side MD stall keeps it from happening.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_start && (r_cnt == '0)) begin
      r_cnt <= i_is_div ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (r_cnt != '0) begin
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  assign o_busy = (r_cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stall/forward decisions and mult/div busy tracking.
// Optional stall statistics counter is enabled by defining HAZARD_STALL_STATS_EN.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_W-1:0]     D_A1,
  input  logic [REG_W-1:0]     D_A2,
  input  logic                 D_A1use,
  input  logic                 D_A2use,
  input  logic [TUSE_W-1:0]    D_Tuse_rs,
  input  logic [TUSE_W-1:0]    D_Tuse_rt,
  input  logic                 D_Is_MD,
  input  logic [REG_W-1:0]     E_A3,
  input  logic [REG_W-1:0]     M_A3,
  input  logic [REG_W-1:0]     W_A3,
  input  logic                 E_Reg_Write,
  input  logic                 M_Reg_Write,
  input  logic                 W_Reg_Write,
  input  logic [TNEW_W-1:0]    E_Tnew,
  input  logic [TNEW_W-1:0]    M_Tnew,
  input  logic [REG_W-1:0]     E_A1,
  input  logic [REG_W-1:0]     E_A2,
  input  logic                 E_MD_Start,
  input  logic                 E_MD_Op,
  output logic                 PC_WE,
  output logic                 F_D_RegWE,
  output logic                 D_E_clear,
  output logic [FWD_SEL_W-1:0] D_Fwd_rs,
  output logic [FWD_SEL_W-1:0] D_Fwd_rt,
  output logic [FWD_SEL_W-1:0] E_Fwd_rs,
  output logic [FWD_SEL_W-1:0] E_Fwd_rt,
  output logic                 MD_Busy
`ifdef HAZARD_STALL_STATS_EN
  ,
  output logic [31:0]          Stall_Cnt
`endif
);

  logic w_md_busy;
  logic w_stall_rs;
  logic w_stall_rt;
  logic w_stall_md;
  logic w_stall;
  logic w_m_ready;

  hazard_ctrl_md_busy_seq #(
    .MULT_CYCLES (MULT_CYCLES),
    .DIV_CYCLES  (DIV_CYCLES),
    .CNT_W       (CNT_W)
  ) u_md_busy_seq (
    .i_clk    (clk),
    .i_rst_n  (reset),
    .i_start  (E_MD_Start),
    .i_is_div (E_MD_Op),
    .o_busy   (w_md_busy)
  );

  assign MD_Busy   = w_md_busy;
  assign w_m_ready = (M_Tnew == '0);

  always_comb begin
    w_stall_rs = D_A1use &&
        ((reg_match(E_Reg_Write, E_A3, D_A1) && (E_Tnew > TNEW_W'(D_Tuse_rs))) ||
         (reg_match(M_Reg_Write, M_A3, D_A1) && (M_Tnew > TNEW_W'(D_Tuse_rs))));
    w_stall_rt = D_A2use &&
        ((reg_match(E_Reg_Write, E_A3, D_A2) && (E_Tnew > TNEW_W'(D_Tuse_rt))) ||
         (reg_match(M_Reg_Write, M_A3, D_A2) && (M_Tnew > TNEW_W'(D_Tuse_rt))));
    w_stall_md = D_Is_MD && (w_md_busy || E_MD_Start);
    w_stall    = reset && (w_stall_rs || w_stall_rt || w_stall_md);
  end

  // Outputs fall back to pass-through defaults while reset is held low.
  always_comb begin
    PC_WE     = !w_stall;
    F_D_RegWE = !w_stall;
    D_E_clear = w_stall;
    D_Fwd_rs  = FWD_GRF;
    D_Fwd_rt  = FWD_GRF;
    E_Fwd_rs  = FWD_GRF;
    E_Fwd_rt  = FWD_GRF;
    if (reset) begin
      if (reg_match(M_Reg_Write, M_A3, D_A1) && w_m_ready) D_Fwd_rs = FWD_M;
      if (reg_match(M_Reg_Write, M_A3, D_A2) && w_m_ready) D_Fwd_rt = FWD_M;
      if (reg_match(M_Reg_Write, M_A3, E_A1) && w_m_ready) E_Fwd_rs = FWD_M;
      else if (reg_match(W_Reg_Write, W_A3, E_A1))        E_Fwd_rs = FWD_W;
      if (reg_match(M_Reg_Write, M_A3, E_A2) && w_m_ready) E_Fwd_rt = FWD_M;
      else if (reg_match(W_Reg_Write, W_A3, E_A2))        E_Fwd_rt = FWD_W;
    end
  end

`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  assign Stall_Cnt = r_stall_cnt;
`endif

  // E-stage results are never ready early enough to reach D.
  a_no_d_fwd_from_e : assert property (@(posedge clk) (D_Fwd_rs != FWD_E) && (D_Fwd_rt != FWD_E));

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed scenarios followed by random traffic.
module tb_hazard_ctrl;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  typedef struct {
    logic [4:0] d_a1, d_a2;
    logic       d_a1use, d_a2use;
    logic [1:0] tuse_rs, tuse_rt;
    logic       d_is_md;
    logic [4:0] e_a3, m_a3, w_a3;
    logic       e_rw, m_rw, w_rw;
    logic [3:0] e_tnew, m_tnew;
    logic [4:0] e_a1, e_a2;
    logic       md_start, md_op, rst_n;
  } stim_t;

  typedef struct {
    int          cyc;
    logic        pc_we, fd_we, clr, busy;
    logic [1:0]  dfrs, dfrt, efrs, efrt;
    logic [31:0] cnt;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] D_A1, D_A2, E_A3, M_A3, W_A3, E_A1, E_A2;
  logic       D_A1use, D_A2use, D_Is_MD, E_Reg_Write, M_Reg_Write, W_Reg_Write;
  logic [1:0] D_Tuse_rs, D_Tuse_rt;
  logic [3:0] E_Tnew, M_Tnew;
  logic       E_MD_Start, E_MD_Op;
  logic       PC_WE, F_D_RegWE, D_E_clear, MD_Busy;
  logic [1:0] D_Fwd_rs, D_Fwd_rt, E_Fwd_rs, E_Fwd_rt;
`ifdef HAZARD_STALL_STATS_EN
  logic [31:0] Stall_Cnt;
`endif

  hazard_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .D_A1        (D_A1),
    .D_A2        (D_A2),
    .D_A1use     (D_A1use),
    .D_A2use     (D_A2use),
    .D_Tuse_rs   (D_Tuse_rs),
    .D_Tuse_rt   (D_Tuse_rt),
    .D_Is_MD     (D_Is_MD),
    .E_A3        (E_A3),
    .M_A3        (M_A3),
    .W_A3        (W_A3),
    .E_Reg_Write (E_Reg_Write),
    .M_Reg_Write (M_Reg_Write),
    .W_Reg_Write (W_Reg_Write),
    .E_Tnew      (E_Tnew),
    .M_Tnew      (M_Tnew),
    .E_A1        (E_A1),
    .E_A2        (E_A2),
    .E_MD_Start  (E_MD_Start),
    .E_MD_Op     (E_MD_Op),
    .PC_WE       (PC_WE),
    .F_D_RegWE   (F_D_RegWE),
    .D_E_clear   (D_E_clear),
    .D_Fwd_rs    (D_Fwd_rs),
    .D_Fwd_rt    (D_Fwd_rt),
    .E_Fwd_rs    (E_Fwd_rs),
    .E_Fwd_rt    (E_Fwd_rt),
    .MD_Busy     (MD_Busy)
`ifdef HAZARD_STALL_STATS_EN
    ,
    .Stall_Cnt   (Stall_Cnt)
`endif
  );

  always #5 clk = ~clk;

  exp_t sb_q[$];
  int   total = 0;
  int   bad   = 0;

  // Reference state: last cycle index during which the mult/div unit is busy,
  // and the number of stalled cycles seen since the last reset.
  int   cyc      = 0;
  int   busy_end = -1;
  int   stall_n  = 0;

  task automatic chk(input string name, input int c, input logic [31:0] got,
                     input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s cycle=%0d got=%0h want=%0h", name, c, got, want);
    end
  endtask

  function automatic logic hit(input logic we, input logic [4:0] dst, input logic [4:0] src);
    return we && (dst == src) && (src != 5'd0);
  endfunction

  // A source must wait if a producer in E or M still needs more cycles than the consumer can wait.
  function automatic logic src_wait(input stim_t s, input logic [4:0] src, input logic used,
                                    input int tuse);
    if (!used) return 1'b0;
    if (hit(s.e_rw, s.e_a3, src) && int'(s.e_tnew) > tuse) return 1'b1;
    if (hit(s.m_rw, s.m_a3, src) && int'(s.m_tnew) > tuse) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [1:0] d_fwd(input stim_t s, input logic [4:0] src);
    return (hit(s.m_rw, s.m_a3, src) && s.m_tnew == 4'd0) ? 2'd2 : 2'd0;
  endfunction

  function automatic logic [1:0] e_fwd(input stim_t s, input logic [4:0] src);
    if (hit(s.m_rw, s.m_a3, src) && s.m_tnew == 4'd0) return 2'd2;
    if (hit(s.w_rw, s.w_a3, src)) return 2'd3;
    return 2'd0;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '{d_a1: 5'd0, d_a2: 5'd0, d_a1use: 1'b0, d_a2use: 1'b0, tuse_rs: 2'd0, tuse_rt: 2'd0,
          d_is_md: 1'b0, e_a3: 5'd0, m_a3: 5'd0, w_a3: 5'd0, e_rw: 1'b0, m_rw: 1'b0,
          w_rw: 1'b0, e_tnew: 4'd0, m_tnew: 4'd0, e_a1: 5'd0, e_a2: 5'd0, md_start: 1'b0,
          md_op: 1'b0, rst_n: 1'b1};
    return s;
  endfunction

  function automatic stim_t rnd();
    stim_t s;
    s = idle();
    s.d_a1     = 5'($urandom_range(0, 3));
    s.d_a2     = 5'($urandom_range(0, 3));
    s.d_a1use  = 1'($urandom_range(0, 1));
    s.d_a2use  = 1'($urandom_range(0, 1));
    s.tuse_rs  = 2'($urandom_range(0, 2));
    s.tuse_rt  = 2'($urandom_range(0, 2));
    s.d_is_md  = ($urandom_range(0, 2) == 0);
    s.e_a3     = 5'($urandom_range(0, 3));
    s.m_a3     = 5'($urandom_range(0, 3));
    s.w_a3     = 5'($urandom_range(0, 3));
    s.e_rw     = 1'($urandom_range(0, 1));
    s.m_rw     = 1'($urandom_range(0, 1));
    s.w_rw     = 1'($urandom_range(0, 1));
    s.e_tnew   = 4'($urandom_range(0, 3));
    s.m_tnew   = 4'($urandom_range(0, 2));
    s.e_a1     = 5'($urandom_range(0, 3));
    s.e_a2     = 5'($urandom_range(0, 3));
    s.md_start = ($urandom_range(0, 5) == 0);
    s.md_op    = 1'($urandom_range(0, 1));
    s.rst_n    = ($urandom_range(0, 59) != 0);
    return s;
  endfunction

  // Drive one cycle of stimulus and push the response the model predicts for it.
  task automatic apply(input stim_t s);
    exp_t e;
    logic busy, stall;
    @(posedge clk);
    #1;
    D_A1 = s.d_a1; D_A2 = s.d_a2; D_A1use = s.d_a1use; D_A2use = s.d_a2use;
    D_Tuse_rs = s.tuse_rs; D_Tuse_rt = s.tuse_rt; D_Is_MD = s.d_is_md;
    E_A3 = s.e_a3; M_A3 = s.m_a3; W_A3 = s.w_a3;
    E_Reg_Write = s.e_rw; M_Reg_Write = s.m_rw; W_Reg_Write = s.w_rw;
    E_Tnew = s.e_tnew; M_Tnew = s.m_tnew; E_A1 = s.e_a1; E_A2 = s.e_a2;
    E_MD_Start = s.md_start; E_MD_Op = s.md_op; reset = s.rst_n;

    busy  = (cyc <= busy_end);
    stall = s.rst_n && (src_wait(s, s.d_a1, s.d_a1use, int'(s.tuse_rs)) ||
                        src_wait(s, s.d_a2, s.d_a2use, int'(s.tuse_rt)) ||
                        (s.d_is_md && (busy || s.md_start)));
    e.cyc   = cyc;
    e.busy  = busy;
    e.pc_we = !stall;
    e.fd_we = !stall;
    e.clr   = stall;
    e.dfrs  = s.rst_n ? d_fwd(s, s.d_a1) : 2'd0;
    e.dfrt  = s.rst_n ? d_fwd(s, s.d_a2) : 2'd0;
    e.efrs  = s.rst_n ? e_fwd(s, s.e_a1) : 2'd0;
    e.efrt  = s.rst_n ? e_fwd(s, s.e_a2) : 2'd0;
    e.cnt   = 32'(stall_n);
    sb_q.push_back(e);

    if (!s.rst_n) begin
      busy_end = cyc;
      stall_n  = 0;
    end else begin
      if (s.md_start && !busy) busy_end = cyc + (s.md_op ? DIV_N : MULT_N);
      if (stall) stall_n++;
    end
    cyc++;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_we",    e.cyc, 32'(PC_WE),     32'(e.pc_we));
        chk("fd_we",    e.cyc, 32'(F_D_RegWE), 32'(e.fd_we));
        chk("de_clear", e.cyc, 32'(D_E_clear), 32'(e.clr));
        chk("md_busy",  e.cyc, 32'(MD_Busy),   32'(e.busy));
        chk("d_fwd_rs", e.cyc, 32'(D_Fwd_rs),  32'(e.dfrs));
        chk("d_fwd_rt", e.cyc, 32'(D_Fwd_rt),  32'(e.dfrt));
        chk("e_fwd_rs", e.cyc, 32'(E_Fwd_rs),  32'(e.efrs));
        chk("e_fwd_rt", e.cyc, 32'(E_Fwd_rt),  32'(e.efrt));
`ifdef HAZARD_STALL_STATS_EN
        chk("stall_cnt", e.cyc, Stall_Cnt, e.cnt);
`endif
      end
    end
  end

  initial begin : driver
    stim_t s;
    s = idle();
    s.rst_n = 1'b0;
    D_A1 = 5'd0; D_A2 = 5'd0; D_A1use = 1'b0; D_A2use = 1'b0; D_Tuse_rs = 2'd0;
    D_Tuse_rt = 2'd0; D_Is_MD = 1'b0; E_A3 = 5'd0; M_A3 = 5'd0; W_A3 = 5'd0;
    E_Reg_Write = 1'b0; M_Reg_Write = 1'b0; W_Reg_Write = 1'b0; E_Tnew = 4'd0;
    M_Tnew = 4'd0; E_A1 = 5'd0; E_A2 = 5'd0; E_MD_Start = 1'b0; E_MD_Op = 1'b0;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    apply(s);

    // Load-use on $1: stall while the load is in E and M, then forward from M.
    s = idle();
    s.d_a1 = 5'd1; s.d_a1use = 1'b1; s.tuse_rs = 2'd0;
    s.e_a3 = 5'd1; s.e_rw = 1'b1; s.e_tnew = 4'd2;
    apply(s);
    s.e_rw = 1'b0; s.m_a3 = 5'd1; s.m_rw = 1'b1; s.m_tnew = 4'd1;
    apply(s);
    s.m_tnew = 4'd0;
    apply(s);

    // Writes to $0 neither stall nor forward.
    s = idle();
    s.d_a1 = 5'd0; s.d_a1use = 1'b1; s.e_a3 = 5'd0; s.e_rw = 1'b1; s.e_tnew = 4'd1;
    s.m_a3 = 5'd0; s.m_rw = 1'b1;
    apply(s);

    // E-side priority: M over W, then W alone.
    s = idle();
    s.e_a1 = 5'd5; s.m_a3 = 5'd5; s.m_rw = 1'b1; s.w_a3 = 5'd5; s.w_rw = 1'b1;
    apply(s);
    s.m_rw = 1'b0;
    apply(s);

    // Divide: busy for ten cycles, MD instruction in D stalls until released.
    s = idle();
    s.md_start = 1'b1; s.md_op = 1'b1;
    apply(s);
    s = idle();
    s.d_is_md = 1'b1;
    repeat (DIV_N + 2) apply(s);

    // Multiply aborted by reset on its third busy cycle, then restarted.
    s = idle();
    s.md_start = 1'b1;
    apply(s);
    s = idle();
    repeat (2) apply(s);
    s.rst_n = 1'b0;
    apply(s);
    s = idle();
    apply(s);
    s.md_start = 1'b1;
    apply(s);
    s = idle();
    repeat (MULT_N + 1) apply(s);

    for (int i = 0; i < 1500; i++) apply(rnd());

    repeat (2) @(negedge clk);
    chk("sb_drained", cyc, 32'(sb_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
